// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART TX channel between
// NUM_REQ byte-stream requesters. It is the only master on the UART register
// bus: it polls the status register for tx_buf_empty, then writes the granted
// requester's byte to the data register. An optional packet lock holds a grant
// until a byte tagged last is sent, so that packets do not interleave.
//
// Handshake: requester i presents req_valid[i] with req_data/req_last held
// stable. The byte is consumed in the single cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is one-hot and lasts one cycle.
//
// UART bus read data is named bus_do because "do" is a reserved word.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ID_W         = 1,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic                 cs,
  output logic                 data_reg,
  output logic                 wren,
  output logic [7:0]           di,
  input  logic [7:0]           bus_do,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POLL  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               cs_q, cs_d;
  logic               data_reg_q, data_reg_d;
  logic               wren_q, wren_d;
  logic [7:0]         di_q, di_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic               lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;
  logic                 arb_found;
  logic [ID_W-1:0]      arb_id;
  logic [2*NUM_REQ-1:0] rot_valid;
  int                   arb_off;
  int                   arb_sum;

  // Only tx_buf_empty matters; RX status and the other bits are ignored.
  logic unused_do;
  assign unused_do = ^{bus_do[7:2], bus_do[0]};

  // Granted requester's inputs, and the round-robin pick starting at rr_q.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
    rot_valid = {req_valid, req_valid} >> rr_q;
    arb_found = 1'b0;
    arb_off   = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!arb_found && rot_valid[j]) begin
        arb_found = 1'b1;
        arb_off   = j;
      end
    end
    arb_sum = int'(rr_q) + arb_off;
    if (arb_sum >= NUM_REQ) arb_sum = arb_sum - NUM_REQ;
    arb_id = ID_W'(arb_sum);
  end

  // Next state and next registered bus outputs; outputs default to idle.
  always_comb begin
    state_d       = state_q;
    cs_d          = 1'b0;
    data_reg_d    = 1'b0;
    wren_d        = 1'b0;
    di_d          = 8'h00;
    req_ready_d   = '0;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_d          = rr_q;
    lock_d        = lock_q;
    cnt_d         = '0;
    case (state_q)
      S_IDLE: begin
        if (lock_q) begin
          if (sel_valid) begin
            state_d = S_POLL;
            cs_d    = 1'b1;
          end else if (LOCK_TIMEOUT != 0) begin
            if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
              lock_d        = 1'b0;
              grant_valid_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (arb_found) begin
          grant_id_d    = arb_id;
          grant_valid_d = 1'b1;
          state_d       = S_POLL;
          cs_d          = 1'b1;
        end
      end
      S_POLL: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus_do[1]) begin
          // di_q doubles as the latched tx byte for the write cycle.
          state_d    = S_WRITE;
          cs_d       = 1'b1;
          wren_d     = 1'b1;
          data_reg_d = 1'b1;
          di_d       = sel_data;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_d[i] = (grant_id_q == ID_W'(i));
          end
        end else begin
          state_d = S_POLL;
          cs_d    = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (int'(grant_id_q) >= NUM_REQ - 1) rr_d = '0;
        else                                 rr_d = grant_id_q + ID_W'(1);
        if (sel_last) begin
          lock_d        = 1'b0;
          grant_valid_d = 1'b0;
        end else begin
          lock_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state and outputs registered; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cs_q          <= 1'b0;
      data_reg_q    <= 1'b0;
      wren_q        <= 1'b0;
      di_q          <= 8'h00;
      req_ready_q   <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_q          <= '0;
      lock_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cs_q          <= cs_d;
      data_reg_q    <= data_reg_d;
      wren_q        <= wren_d;
      di_q          <= di_d;
      req_ready_q   <= req_ready_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_q          <= rr_d;
      lock_q        <= lock_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign cs          = cs_q;
  assign data_reg    = data_reg_q;
  assign wren        = wren_q;
  assign di          = di_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two requesters, LOCK_TIMEOUT=16, a small UART
// status model, per-requester byte queues and a write scoreboard.
module tb_uart_tx_arbiter;

  localparam int EXP_W = 11;  // {grant_id, req_ready[1:0], di[7:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        grant_valid;
  logic [0:0]  grant_id;
  logic        cs;
  logic        data_reg;
  logic        wren;
  logic [7:0]  di;
  logic [7:0]  bus_do = '0;
  logic [1:0]  state_dbg;

  logic [EXP_W-1:0] exp_q[$];
  logic [8:0]       src0_q[$];   // {last, byte}
  logic [8:0]       src1_q[$];

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int ack_cnt = 0;
  int wr_cyc = 0;
  int poll_cnt = 0;
  int busy_until = 0;
  logic       prev_cs = 1'b0;
  logic [1:0] ack_d = '0;

  uart_tx_arbiter #(.NUM_REQ(2), .ID_W(1), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant_valid(grant_valid), .grant_id(grant_id),
    .cs(cs), .data_reg(data_reg), .wren(wren), .di(di),
    .bus_do(bus_do), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int src, input logic [7:0] b);
    logic [1:0] oh;
    oh = 2'b01 << src;
    exp_q.push_back({1'(src), oh, b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("reset_outs", 32'({cs, wren, data_reg, di, req_ready, grant_valid, grant_id}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (wr_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(wr_cnt), 32'(target));
  endtask

  // UART model: answers a status read on the following cycle; garbage otherwise.
  always @(posedge clk) begin
    if (cs && !wren) begin
      bus_do   <= {6'b0, (poll_cnt >= busy_until), 1'($urandom_range(0, 1))};
      poll_cnt <= poll_cnt + 1;
    end else begin
      bus_do <= 8'($urandom_range(0, 255));
    end
  end

  // Requester driver: retire acked bytes, then present each queue head.
  always @(posedge clk) begin
    #1;
    if (ack_d[0] && src0_q.size() > 0) void'(src0_q.pop_front());
    if (ack_d[1] && src1_q.size() > 0) void'(src1_q.pop_front());
    if (src0_q.size() > 0) begin
      req_valid[0]   = 1'b1;
      req_data[7:0]  = src0_q[0][7:0];
      req_last[0]    = src0_q[0][8];
    end else begin
      req_valid[0]   = 1'b0;
      req_data[7:0]  = 8'($urandom_range(0, 255));
      req_last[0]    = 1'($urandom_range(0, 1));
    end
    if (src1_q.size() > 0) begin
      req_valid[1]   = 1'b1;
      req_data[15:8] = src1_q[0][7:0];
      req_last[1]    = src1_q[0][8];
    end else begin
      req_valid[1]   = 1'b0;
      req_data[15:8] = 8'($urandom_range(0, 255));
      req_last[1]    = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor: every data write is popped and compared.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    cyc++;
    ack_d = req_valid & req_ready;
    check("cs_gap", 32'(prev_cs & cs), 32'd0);
    prev_cs = cs;
    if (req_ready != 2'b00) ack_cnt++;
    if (cs && wren && data_reg) begin
      wr_cnt++;
      wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("exp_avail", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("write", 32'({grant_id, req_ready, di}), 32'(e));
      end
    end
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
      $fatal(1);
    end
  end

  initial begin
    int w0, a0, p0, t;

    // Single byte with exact cycle timing
    do_reset();
    w0 = wr_cnt;
    src0_q.push_back({1'b1, 8'h41});
    push_exp(0, 8'h41);
    @(posedge clk); #2;
    tick();
    check("t1_c0_cs", 32'(cs), 32'd0);
    tick();
    check("t1_c1_bus", 32'({cs, wren, data_reg}), 32'b100);
    check("t1_c1_grant", 32'({grant_valid, grant_id}), 32'b10);
    check("t1_c1_state", 32'(state_dbg), 32'd1);
    tick();
    check("t1_c2_cs", 32'(cs), 32'd0);
    check("t1_c2_state", 32'(state_dbg), 32'd2);
    tick();
    check("t1_c3_bus", 32'({cs, wren, data_reg, di}), 32'({3'b111, 8'h41}));
    check("t1_c3_ready", 32'(req_ready), 32'b01);
    tick();
    check("t1_c4_gv", 32'({grant_valid, req_ready}), 32'd0);
    check("t1_writes", 32'(wr_cnt - w0), 32'd1);

    // Busy UART: three busy polls, then one write
    do_reset();
    w0 = wr_cnt; a0 = ack_cnt; p0 = poll_cnt;
    busy_until = poll_cnt + 3;
    src0_q.push_back({1'b1, 8'h5A});
    push_exp(0, 8'h5A);
    wait_writes("t2_writes", w0 + 1, 60);
    repeat (4) tick();
    check("t2_polls", 32'(poll_cnt - p0), 32'd4);
    check("t2_acks", 32'(ack_cnt - a0), 32'd1);

    // Round robin, every byte last
    do_reset();
    w0 = wr_cnt;
    src0_q.push_back({1'b1, 8'hAA}); src0_q.push_back({1'b1, 8'hAA});
    src1_q.push_back({1'b1, 8'h55}); src1_q.push_back({1'b1, 8'h55});
    push_exp(0, 8'hAA); push_exp(1, 8'h55); push_exp(0, 8'hAA); push_exp(1, 8'h55);
    wait_writes("t3_writes", w0 + 4, 80);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Packet lock: three req0 bytes before req1
    do_reset();
    w0 = wr_cnt;
    src0_q.push_back({1'b0, 8'h11}); src0_q.push_back({1'b0, 8'h22});
    src0_q.push_back({1'b1, 8'h33});
    src1_q.push_back({1'b1, 8'h99});
    push_exp(0, 8'h11); push_exp(0, 8'h22); push_exp(0, 8'h33); push_exp(1, 8'h99);
    wait_writes("t4_writes", w0 + 4, 80);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Lock timeout (16): req0 sends one unterminated byte, then goes quiet
    do_reset();
    w0 = wr_cnt;
    src0_q.push_back({1'b0, 8'h77});
    src1_q.push_back({1'b1, 8'h88});
    push_exp(0, 8'h77); push_exp(1, 8'h88);
    wait_writes("t5_first", w0 + 1, 40);
    a0 = wr_cyc;
    while (cyc < a0 + 16) tick();
    check("t5_held", 32'({grant_valid, grant_id}), 32'b10);
    tick();
    check("t5_released", 32'(grant_valid), 32'd0);
    tick();
    check("t5_regrant", 32'({grant_valid, grant_id}), 32'b11);
    wait_writes("t5_second", w0 + 2, 40);
    check("t5_gap", 32'(wr_cyc - a0), 32'd20);

    // Reset while waiting on status: byte must survive and go out once
    do_reset();
    w0 = wr_cnt; a0 = ack_cnt;
    src0_q.push_back({1'b1, 8'hC3});
    push_exp(0, 8'hC3);
    t = 0;
    while (state_dbg != 2'd2 && t < 10) begin
      tick();
      t++;
    end
    check("t6_in_wait", 32'(state_dbg), 32'd2);
    reset = 1'b1;
    tick();
    check("t6_reset_outs", 32'({cs, wren, data_reg, di, req_ready, grant_valid, grant_id}), 32'd0);
    check("t6_reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    wait_writes("t6_writes", w0 + 1, 40);
    repeat (10) tick();
    check("t6_once", 32'(wr_cnt - w0), 32'd1);
    check("t6_acks", 32'(ack_cnt - a0), 32'd1);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
